// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with stall and error reporting
//
// Services one load or store at a time. The access completes with a one-cycle
// ack_o pulse LATENCY cycles after acceptance. err_o flags misaligned or
// out-of-range accesses.
// Optional feature macro: DMEM_RESP_BYTE_STROBE_EN (adds per-byte store enables).
//
// Ports:
//   clk_i    - clock
//   rst_i    - synchronous active-high reset
//   req_i    - access request
//   we_i     - 1 = store, 0 = load
//   addr_i   - byte address
//   wdata_i  - store data
//   be_i     - byte enables for stores (only with DMEM_RESP_BYTE_STROBE_EN)
//   rdata_o  - load data, non-zero only during the ack cycle
//   ack_o    - one-cycle completion pulse
//   err_o    - error flag qualifying ack_o
//   stall_o  - pipeline freeze request
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
`ifdef DMEM_RESP_BYTE_STROBE_EN
  input  logic [3:0]  be_i,
`endif
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_take;
  logic          w_commit;
  logic          w_we;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [3:0]    w_be;
  logic          w_err;
  logic [AW-1:0] w_idx;

  assign w_take = (r_state == S_IDLE) && req_i;

  // With LATENCY = 1 the acceptance edge is also the commit edge, so the
  // access is taken straight from the inputs; otherwise from the latches.
  assign w_we    = w_take ? we_i    : r_we;
  assign w_addr  = w_take ? addr_i  : r_addr;
  assign w_wdata = w_take ? wdata_i : r_wdata;

`ifdef DMEM_RESP_BYTE_STROBE_EN
  logic [3:0] r_be;
  assign w_be = w_take ? be_i : r_be;
`else
  assign w_be = 4'hF;
`endif

  // Commit happens on the edge that enters ACK.
  assign w_commit = (w_take && (LATENCY == 1)) ||
                    ((r_state == S_WAIT) && (r_cnt == CW'(1)));

  // Anything at or above 4*DEPTH_WORDS has a non-zero bit above the index.
  assign w_err = (w_addr[1:0] != 2'b00) || (w_addr[31:AW+2] != '0);
  assign w_idx = w_addr[AW+1:2];

  assign stall_o = w_take || (r_state == S_WAIT);

  // Array contents survive reset; only the commit is suppressed.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_commit && w_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
`ifdef DMEM_RESP_BYTE_STROBE_EN
      r_be    <= '0;
`endif
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_we    <= we_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
`ifdef DMEM_RESP_BYTE_STROBE_EN
            r_be    <= be_i;
`endif
            if (LATENCY == 1) begin
              r_state <= S_ACK;
            end else begin
              r_cnt   <= CW'(LATENCY - 1);
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Outputs are only non-zero in the cycle after a commit, i.e. in ACK.
      ack_o   <= w_commit;
      err_o   <= w_commit && w_err;
      rdata_o <= (w_commit && !w_we && !w_err) ? r_mem[w_idx] : 32'h0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam int L     = 4;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we_s;
  logic [31:0] addr_s, wdata_s;
  logic [3:0]  be_s;
  logic [31:0] rdata;
  logic        ack, err, stall;

  logic        req1, we1;
  logic [31:0] addr1, wdata1;
  logic [3:0]  be1;
  logic [31:0] rdata1;
  logic        ack1, err1, stall1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we_s),
    .addr_i(addr_s), .wdata_i(wdata_s),
`ifdef DMEM_RESP_BYTE_STROBE_EN
    .be_i(be_s),
`endif
    .rdata_o(rdata), .ack_o(ack), .err_o(err), .stall_o(stall)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1),
    .addr_i(addr1), .wdata_i(wdata1),
`ifdef DMEM_RESP_BYTE_STROBE_EN
    .be_i(be1),
`endif
    .rdata_o(rdata1), .ack_o(ack1), .err_o(err1), .stall_o(stall1)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rd;
    string       nm;
  } vec_t;

  vec_t        tbl [12];
  logic [31:0] model_mem [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full access on the LATENCY=4 instance, checking every cycle 0..L+1.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic exp_err,
                        input logic [31:0] exp_rd, input string nm);
    @(negedge clk);
    req = 1'b1; we_s = w; addr_s = a; wdata_s = d; be_s = be;
    #1;
    chk({nm, ":stall_c0"}, 32'(stall), 32'd1);
    chk({nm, ":ack_c0"}, 32'(ack), 32'd0);
    for (int c = 1; c <= L + 1; c++) begin
      @(negedge clk);
      req     = (c < L) ? 1'($urandom_range(0, 1)) : (c == L);
      we_s    = 1'($urandom);
      addr_s  = $urandom;
      wdata_s = $urandom;
      be_s    = 4'($urandom);
      #1;
      if (c < L) begin
        chk({nm, ":stall_wait"}, 32'(stall), 32'd1);
        chk({nm, ":ack_wait"}, 32'(ack), 32'd0);
      end else if (c == L) begin
        chk({nm, ":ack"}, 32'(ack), 32'd1);
        chk({nm, ":stall_ack"}, 32'(stall), 32'd0);
        chk({nm, ":err"}, 32'(err), 32'(exp_err));
        chk({nm, ":rdata"}, rdata, exp_rd);
      end else begin
        chk({nm, ":ack_after"}, 32'(ack), 32'd0);
        chk({nm, ":rdata_after"}, rdata, 32'd0);
        chk({nm, ":stall_after"}, 32'(stall), 32'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] a, d, exp_rd;
    logic        w, e;
    logic [3:0]  be;
    int          wi;

    tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        "st_10"};
    tbl[1]  = '{1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, "ld_10"};
    tbl[2]  = '{1'b1, 32'h0,   32'h0BADF00D, 1'b0, 32'h0,        "st_00"};
    tbl[3]  = '{1'b0, 32'h11,  32'h0,        1'b1, 32'h0,        "ld_misal"};
    tbl[4]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 1'b1, 32'h0,        "st_oor"};
    tbl[5]  = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h0BADF00D, "ld_00"};
    tbl[6]  = '{1'b1, 32'h20,  32'hCAFEF00D, 1'b0, 32'h0,        "st_20"};
    tbl[7]  = '{1'b1, 32'h3FC, 32'h13579BDF, 1'b0, 32'h0,        "st_last"};
    tbl[8]  = '{1'b0, 32'h3FC, 32'h0,        1'b0, 32'h13579BDF, "ld_last"};
    tbl[9]  = '{1'b1, 32'h3FE, 32'h0,        1'b1, 32'h0,        "st_misal"};
    tbl[10] = '{1'b0, 32'h3FC, 32'h0,        1'b0, 32'h13579BDF, "ld_last2"};
    tbl[11] = '{1'b0, 32'hFFFFFFFC, 32'h0,   1'b1, 32'h0,        "ld_high"};

    rst = 1'b1; req = 1'b1; we_s = 1'b0; addr_s = 32'h0; wdata_s = 32'h0; be_s = 4'hF;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0; be1 = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    chk("rst:ack", 32'(ack), 32'd0);
    chk("rst:err", 32'(err), 32'd0);
    chk("rst:rdata", rdata, 32'd0);
    chk("rst:stall_req1", 32'(stall), 32'd1);
    req = 1'b0;
    #1;
    chk("rst:stall_req0", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      access(tbl[i].we, tbl[i].addr, tbl[i].wdata, 4'hF, tbl[i].err, tbl[i].rd, tbl[i].nm);
    end

    // Reset during WAIT drops an uncommitted store.
    @(negedge clk);
    req = 1'b1; we_s = 1'b1; addr_s = 32'h20; wdata_s = 32'h12345678; be_s = 4'hF;
    #1;
    chk("abort:stall_c0", 32'(stall), 32'd1);
    @(negedge clk);
    req = 1'b0;
    #1;
    chk("abort:stall_c1", 32'(stall), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort:ack", 32'(ack), 32'd0);
    chk("abort:err", 32'(err), 32'd0);
    chk("abort:rdata", rdata, 32'd0);
    chk("abort:stall", 32'(stall), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("abort:no_ack", 32'(ack), 32'd0);
    end
    access(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D, "abort:ld_20");

    // LATENCY=1 instance with req held high throughout.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req1 = 1'b1; be1 = 4'hF;
      case (i)
        0:       begin we1 = 1'b1; addr1 = 32'h4; wdata1 = 32'h55AA33CC; end
        2:       begin we1 = 1'b0; addr1 = 32'h4; end
        4:       begin we1 = 1'b0; addr1 = 32'h9; end
        6:       begin we1 = 1'b0; addr1 = 32'h4; end
        default: begin we1 = 1'($urandom); addr1 = $urandom; wdata1 = $urandom; end
      endcase
      #1;
      chk("lat1:stall", 32'(stall1), 32'(i % 2 == 0));
      chk("lat1:ack", 32'(ack1), 32'(i % 2 == 1));
      if (i == 3) chk("lat1:rdata", rdata1, 32'h55AA33CC);
      if (i == 5) chk("lat1:err", 32'(err1), 32'd1);
      if (i == 7) chk("lat1:rdata2", rdata1, 32'h55AA33CC);
    end
    @(negedge clk);
    req1 = 1'b0;

`ifdef DMEM_RESP_BYTE_STROBE_EN
    access(1'b1, 32'h8, 32'hAABBCCDD, 4'hF,    1'b0, 32'h0,        "be:st_full");
    access(1'b1, 32'h8, 32'h11223344, 4'b0101, 1'b0, 32'h0,        "be:st_0101");
    access(1'b0, 32'h8, 32'h0,        4'hF,    1'b0, 32'hAA22CC44, "be:ld");
    access(1'b1, 32'h8, 32'h99999999, 4'h0,    1'b0, 32'h0,        "be:st_none");
    access(1'b0, 32'h8, 32'h0,        4'h0,    1'b0, 32'hAA22CC44, "be:ld_be0");
`endif

    // Randomized traffic against a word-array model over words 0..15.
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = $urandom;
      access(1'b1, 32'(i * 4), model_mem[i], 4'hF, 1'b0, 32'h0, "rnd:prefill");
    end
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        1:       a = 32'd1024 + 32'($urandom_range(0, 100000) * 4);
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      w  = 1'($urandom);
      d  = $urandom;
`ifdef DMEM_RESP_BYTE_STROBE_EN
      be = 4'($urandom);
`else
      be = 4'hF;
`endif
      e  = (a % 4 != 0) || (a >= 32'(4 * DEPTH));
      wi = int'(a / 4) % 16;
      exp_rd = (!w && !e) ? model_mem[wi] : 32'h0;
      access(w, a, d, be, e, exp_rd, "rnd:access");
      if (w && !e) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model_mem[wi][8*b +: 8] = d[8*b +: 8];
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
